apb_master: RTL and testbench
=============================

# apb_master

APB initiator that turns a single-entry command/response interface into APB SETUP/ACCESS transfers. Supports wait states through `ready`, error return through `slv_err`, and a programmable wait-state timeout. It sits between an internal controller (CPU bridge, sequencer or test driver) and the APB register slaves on the peripheral bus. It issues one transfer at a time and has no outstanding-transaction queue.

## Interface
Parameters:
- `width_addr`, default 8: APB address width.
- `width_data`, default 32: APB data width.
- `timeout`, default 16: maximum ACCESS cycles waiting for `ready`. A value of 0 disables the timeout.

Ports:
- `clk`  in  1: bus clock (PCLK). All logic is on the rising edge.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `cmd_valid`  in  1: a command is presented.
- `cmd_ready`  out  1: the block can accept a command.
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  width_addr: transfer address.
- `cmd_wdata`  in  width_data: write data. Ignored for reads.
- `rsp_valid`  out  1: one-cycle pulse indicating the transfer completed.
- `rsp_rdata`  out  width_data: read data. Forced to 0 for writes.
- `rsp_err`  out  1: slave error or timeout, qualified by `rsp_valid`.
- `rsp_timeout`  out  1: the transfer was ended by timeout, qualified by `rsp_valid`.
- `select`  out  1: PSEL.
- `wr_ena`  out  1: PWRITE.
- `en_vld`  out  1: PENABLE.
- `addr`  out  width_addr: PADDR.
- `wr_data`  out  width_data: PWDATA.
- `rd_data`  in  width_data: PRDATA.
- `ready`  in  1: PREADY. Tie to 1 for slaves without wait states.
- `slv_err`  in  1: PSLVERR. Tie to 0 if unused.

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS. It is one-hot encoded.
- IDLE:
  - `cmd_ready`=1, `select`=0, `en_vld`=0.
  - When `cmd_valid && cmd_ready` is true at a rising edge, the block registers `cmd_write`/`cmd_addr`/`cmd_wdata` into `wr_ena`/`addr`/`wr_data` and moves to SETUP.
- SETUP: `select`=1, `en_vld`=0. The next state is always ACCESS.
- ACCESS:
  - `select`=1, `en_vld`=1.
  - If `ready`=1 at the edge, the transfer completes and the state returns to IDLE.
  - Otherwise the state stays in ACCESS and the wait counter increments.
- Bus signal stability:
  - `addr`, `wr_data` and `wr_ena` hold their values from SETUP through the final ACCESS cycle.
  - After completion they keep their last values; they are not cleared.
- Completion edge:
  - `rsp_valid`<=1 for exactly one cycle.
  - `rsp_err`<=`slv_err`.
  - `rsp_timeout`<=0.
  - `rsp_rdata`<=`rd_data` if the transfer is a read, else 0.
- Wait counter:
  - Width is $clog2(timeout+1).
  - It clears on entry to ACCESS.
  - If `timeout`>0 and the counter reaches `timeout`-1 while `ready`=0, the next edge ends the transfer:
    - The state returns to IDLE.
    - `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
    - `select`/`en_vld` drop.
  - With `timeout`=0 the block waits indefinitely.
- No response backpressure:
  - The requester must accept `rsp_*` in the cycle `rsp_valid` is high.
  - `rsp_rdata`/`rsp_err`/`rsp_timeout` hold until the next completion.
- `slv_err` and `rd_data` are sampled only on the completion edge. Values in other cycles are ignored.

## Timing
- Reset values (state = IDLE):
  - `select`=0, `en_vld`=0, `wr_ena`=0, `addr`=0, `wr_data`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `rsp_timeout`=0.
  - `cmd_ready`=0 while `rst` is high, and 1 from the first cycle after `rst` deasserts.
- Zero-wait transfer:
  - Command accepted at edge E0.
  - SETUP during cycle E0..E1.
  - ACCESS during E1..E2.
  - `rsp_valid` is high during E2..E3.
- Latency is 2 + N edges from acceptance to `rsp_valid`, where N = wait cycles.
- `cmd_ready` is combinational from state (IDLE).
- A new command may be accepted in the same cycle `rsp_valid` is high. Back-to-back throughput is one transfer per 3 cycles, with no idle bus cycle beyond IDLE.
- Reset mid-transfer: at the next edge the block returns to IDLE, `select`/`en_vld` go to 0, no `rsp_valid` is generated, and the in-flight command is discarded.
- `cmd_valid` deasserting while not accepted has no effect. Command inputs are not sampled outside the acceptance edge.
- If `ready`=1 and the timeout threshold are reached in the same cycle, `ready` wins: normal completion, `rsp_timeout`=0.

## Test plan
- Zero-wait write of addr 0x10, data 0xDEADBEEF (`ready`=1):
  - `select` high 2 cycles, `en_vld` high 1 cycle, `wr_ena`=1, stable addr/data.
  - `rsp_valid` 2 edges after acceptance, `rsp_err`=0, `rsp_rdata`=0.
- Read of 0x10 with `rd_data`=0xCAFEF00D driven and 3 wait cycles (`ready` low 3 ACCESS cycles):
  - ACCESS lasts 4 cycles.
  - `rsp_rdata`=0xCAFEF00D, `rsp_valid` 5 edges after acceptance.
- Back-to-back: `cmd_valid` held high with write 0x01 then read 0x02 → second acceptance in the `rsp_valid` cycle of the first; bus shows SETUP/ACCESS/IDLE/SETUP/ACCESS.
- `slv_err`=1 on the completing ACCESS of a write → `rsp_err`=1, `rsp_timeout`=0. The next transfer with `slv_err`=0 returns `rsp_err`=0.
- Timeout=16 with `ready` held 0:
  - After 16 ACCESS cycles, `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0, and `select` drops.
  - Repeat with `ready`=1 on exactly the 16th cycle → normal completion.
- `rst` asserted during ACCESS of a read:
  - The next edge shows `select`=0, `en_vld`=0 and no `rsp_valid`, with all outputs at reset values.
  - A command after reset release completes normally.

Source files
------------

// File: rtl/apb_master.sv
// APB initiator: accepts one command at a time and runs it as an APB SETUP/ACCESS
// transfer, returning a single-cycle response with read data, slave error or timeout.
module apb_master #(
  parameter int width_addr = 8,
  parameter int width_data = 32,
  parameter int timeout    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [width_addr-1:0] cmd_addr,
  input  logic [width_data-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [width_data-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  select,
  output logic                  wr_ena,
  output logic                  en_vld,
  output logic [width_addr-1:0] addr,
  output logic [width_data-1:0] wr_data,
  input  logic [width_data-1:0] rd_data,
  input  logic                  ready,
  input  logic                  slv_err,
  output logic [2:0]            dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // rsp_valid is a one-cycle pulse with no backpressure.
  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    SETUP  = 3'b010,
    ACCESS = 3'b100
  } state_t;

  localparam int cnt_w = (timeout > 0) ? $clog2(timeout + 1) : 1;
  localparam logic [cnt_w-1:0] last_cnt = (timeout > 0) ? cnt_w'(timeout - 1) : '0;

  state_t           state;
  logic [cnt_w-1:0] wait_cnt;

  assign cmd_ready = (state == IDLE) && !rst;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      select      <= 1'b0;
      en_vld      <= 1'b0;
      wr_ena      <= 1'b0;
      addr        <= '0;
      wr_data     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wr_ena  <= cmd_write;
            addr    <= cmd_addr;
            wr_data <= cmd_wdata;
            select  <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          en_vld   <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // ready takes priority over a timeout reached in the same cycle
          if (ready) begin
            state       <= IDLE;
            select      <= 1'b0;
            en_vld      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= slv_err;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= wr_ena ? '0 : rd_data;
          end else if ((timeout > 0) && (wait_cnt == last_cnt)) begin
            state       <= IDLE;
            select      <= 1'b0;
            en_vld      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else begin
            wait_cnt <= wait_cnt + cnt_w'(1);
          end
        end
        default: begin
          state  <= IDLE;
          select <= 1'b0;
          en_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: table of directed transfers, random transfers against a
// transaction-level model, and a reset-during-ACCESS sequence.
module tb_apb_master;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        select;
  logic        wr_ena;
  logic        en_vld;
  logic [7:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data = '0;
  logic        ready = 1'b0;
  logic        slv_err = 1'b0;
  logic [2:0]  dbg_state;

  apb_master #(.width_addr(8), .width_data(32), .timeout(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .select(select), .wr_ena(wr_ena), .en_vld(en_vld), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .slv_err(slv_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    bit          write;
    logic [7:0]  a;
    logic [31:0] wdata;
    int          nwait;      // ready low for this many ACCESS cycles
    logic [31:0] rdata;      // PRDATA shown on the completing cycle
    bit          err;        // PSLVERR shown on the completing cycle
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_to;
    int          exp_lat;    // edges from acceptance to rsp_valid
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];
  logic [33:0] last_rsp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: the outcome depends only on how long ready stays low.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (TIMEOUT > 0 && v.nwait >= TIMEOUT) begin
      r.exp_lat = 1 + TIMEOUT; r.exp_rdata = '0; r.exp_err = 1'b1; r.exp_to = 1'b1;
    end else begin
      r.exp_lat = 2 + v.nwait; r.exp_rdata = v.write ? 32'h0 : v.rdata;
      r.exp_err = v.err; r.exp_to = 1'b0;
    end
    return r;
  endfunction

  // Driver: called at a negedge with the DUT idle; returns at the negedge of the rsp_valid cycle.
  task automatic xfer(input vec_t v);
    logic [33:0] e;
    exp_q.push_back({v.exp_to, v.exp_err, v.exp_rdata});
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.a; cmd_wdata = v.wdata;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = $urandom;
    for (int k = 0; k < v.exp_lat; k++) begin
      chk("select", select, 1);
      chk("en_vld", en_vld, (k > 0) ? 1 : 0);
      chk("addr", addr, v.a);
      chk("wr_data", wr_data, v.wdata);
      chk("wr_ena", wr_ena, v.write);
      chk("rsp_valid_busy", rsp_valid, 0);
      chk("cmd_ready_busy", cmd_ready, 0);
      if (k == 0) begin
        ready = 1'($urandom); rd_data = $urandom; slv_err = 1'($urandom);
      end else if (k == v.nwait + 1) begin
        ready = 1'b1; rd_data = v.rdata; slv_err = v.err;
      end else begin
        ready = 1'b0; rd_data = $urandom; slv_err = 1'($urandom);
      end
      @(negedge clk);
    end
    ready = 1'b0; rd_data = $urandom; slv_err = 1'($urandom);
    chk("rsp_valid", rsp_valid, 1);
    chk("select_done", select, 0);
    chk("en_vld_done", en_vld, 0);
    chk("cmd_ready_done", cmd_ready, 1);
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk("rsp_rdata", rsp_rdata, e[31:0]);
      chk("rsp_err", rsp_err, e[32]);
      chk("rsp_timeout", rsp_timeout, e[33]);
      last_rsp = e;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_select", select, 0);
    chk("idle_hold_rsp", {rsp_timeout, rsp_err, rsp_rdata}, last_rsp);
  endtask

  vec_t tbl[8];
  vec_t v;

  initial begin
    //            w   addr   wdata         nw  rdata         err  exp_rdata    e  to lat
    tbl[0] = '{1'b1, 8'h10, 32'hDEADBEEF,  0, 32'h11111111, 1'b0, 32'h0,        0, 0, 2};
    tbl[1] = '{1'b0, 8'h10, 32'h0,         3, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 0, 0, 5};
    tbl[2] = '{1'b1, 8'h01, 32'h00000001,  0, 32'h22222222, 1'b0, 32'h0,        0, 0, 2};
    tbl[3] = '{1'b0, 8'h02, 32'h0,         0, 32'h12345678, 1'b0, 32'h12345678, 0, 0, 2};
    tbl[4] = '{1'b1, 8'h20, 32'hA5A5A5A5,  1, 32'h33333333, 1'b1, 32'h0,        1, 0, 3};
    tbl[5] = '{1'b1, 8'h24, 32'h5A5A5A5A,  0, 32'h44444444, 1'b0, 32'h0,        0, 0, 2};
    tbl[6] = '{1'b0, 8'h30, 32'h0,        16, 32'h55555555, 1'b0, 32'h0,        1, 1, 17};
    tbl[7] = '{1'b0, 8'h34, 32'h0,        15, 32'h66666666, 1'b0, 32'h66666666, 0, 0, 17};

    // reset values
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_select", select, 0);
    chk("rst_en_vld", en_vld, 0);
    chk("rst_bus", {wr_ena, addr, wr_data}, 0);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_err, rsp_rdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // directed table; entries 2/3 run back-to-back, the rest with one idle cycle between
    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i]);
      if (i != 2) idle_cycle();
    end

    // random transfers against the reference model
    for (int i = 0; i < 40; i++) begin
      v.write = 1'($urandom); v.a = 8'($urandom); v.wdata = $urandom;
      v.nwait = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 20) : $urandom_range(0, 5);
      v.rdata = $urandom; v.err = ($urandom_range(0, 3) == 0);
      v = model(v);
      xfer(v);
      for (int j = $urandom_range(0, 2); j > 0; j--) idle_cycle();
    end

    // make rsp_rdata non-zero, then reset during ACCESS of a read
    v = model('{1'b0, 8'h40, 32'h0, 0, 32'hFACEB00C, 1'b0, 32'h0, 0, 0, 0});
    xfer(v);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44; ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_access_en", en_vld, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_select", select, 0);
    chk("mid_rst_en_vld", en_vld, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_bus", {wr_ena, addr, wr_data}, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_timeout, rsp_err, rsp_rdata}, 0);
    rst = 1'b0;
    last_rsp = '0;
    @(negedge clk);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    v = model('{1'b0, 8'h48, 32'h0, 2, 32'h0BADF00D, 1'b0, 32'h0, 0, 0, 0});
    xfer(v);
    idle_cycle();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
